// File: rtl/data_bus_responder.sv
// Data-bus responder: word-addressed RAM, cycle counter and console TX FIFO behind one decoder.
// Optional feature: define DATA_BUS_RESPONDER_CYCLE_COUNTER_EN to implement the CYCLE register.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_tx_valid,
  output logic [31:0] o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_overflow
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [13:0] WA_CYCLE  = 14'h3C00;
  localparam logic [13:0] WA_TXDATA = 14'h3C01;
  localparam logic [13:0] WA_STATUS = 14'h3C02;

  // Address decode; byte-lane bits are not part of any word address.
  logic [13:0]       word_addr;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_ram, sel_cycle, sel_txdata, sel_status;
  logic              wr_en;
  logic              unused_addr_lsb;

  assign word_addr       = i_address[15:2];
  assign ram_idx         = i_address[RAM_AW+1:2];
  assign sel_ram         = ~i_address[15];
  assign sel_cycle       = (word_addr == WA_CYCLE);
  assign sel_txdata      = (word_addr == WA_TXDATA);
  assign sel_status      = (word_addr == WA_STATUS);
  assign wr_en           = i_rw & ~i_reset;
  assign unused_addr_lsb = ^i_address[1:0];

  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge i_clk) begin
    if (wr_en && sel_ram) begin
      ram_q[ram_idx] <= i_data;
    end
  end

  // TX FIFO control state.
  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fifo_empty, fifo_full;
  logic             pop, push_req, push;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = ~fifo_empty & i_tx_ready & ~i_reset;
  assign push_req   = wr_en & sel_txdata;
  assign push       = push_req & (~fifo_full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end else if (wr_en && sel_status && i_data[16]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= i_data;
    end
  end

  logic [31:0] cycle_rd;

`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
  // A CPU write to CYCLE takes priority over the increment.
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wr_en && sel_cycle) begin
      cycle_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_rd = i_reset ? 32'd0 : cycle_q;
`else
  assign cycle_rd = 32'd0;
`endif

  // Reset forces the visible FIFO/status view to empty before the first edge.
  logic [31:0] status_rd;

  assign status_rd  = i_reset ? 32'h0000_0001
                              : {15'b0, ovf_q, 8'(count_q), 6'b0, fifo_full, fifo_empty};
  assign o_tx_valid = ~fifo_empty & ~i_reset;
  assign o_tx_data  = (fifo_empty || i_reset) ? 32'd0 : fifo_q[rd_ptr_q];
  assign o_overflow = ovf_q & ~i_reset;

  always_comb begin
    o_data = 32'd0;
    if (sel_ram) begin
      o_data = ram_q[ram_idx];
    end else if (sel_cycle) begin
      o_data = cycle_rd;
    end else if (sel_status) begin
      o_data = status_rd;
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: queue/array reference model checked every cycle, plus literal pins.
module tb_data_bus_responder;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        rw;
  logic [31:0] wdata;
  logic        tx_ready;
  logic [31:0] o_data;
  logic        o_tx_valid;
  logic [31:0] o_tx_data;
  logic        o_overflow;

  data_bus_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_address (addr),
    .i_rw      (rw),
    .i_data    (wdata),
    .o_data    (o_data),
    .o_tx_valid(o_tx_valid),
    .o_tx_data (o_tx_data),
    .i_tx_ready(tx_ready),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: sparse RAM, queue FIFO, sticky flag, counter.
  logic [31:0] m_ram [int];
  logic [31:0] m_q [$];
  bit          m_ovf = 1'b0;
  logic [31:0] m_cyc = 32'd0;

  always @(posedge clk) begin : model_update
    int widx;
    widx = int'(addr[15:2]) % RAM_WORDS;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
    end else begin
      if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
      m_cyc = m_cyc + 32'd1;
      if (rw) begin
        if (addr < 16'h8000) m_ram[widx] = wdata;
        else if (addr[15:2] == 14'h3C00) m_cyc = wdata;
        else if (addr[15:2] == 14'h3C01) begin
          if (m_q.size() < FIFO_DEPTH) m_q.push_back(wdata);
          else m_ovf = 1'b1;
        end else if (addr[15:2] == 14'h3C02 && wdata[16]) m_ovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int          ridx;
    int          cnt;
    logic [31:0] exp_rd;
    bit          known;
    #2;
    cnt   = m_q.size();
    ridx  = int'(addr[15:2]) % RAM_WORDS;
    known = 1'b1;
    exp_rd = 32'd0;
    if (addr < 16'h8000) begin
      known = m_ram.exists(ridx);
      if (known) exp_rd = m_ram[ridx];
    end else if (addr[15:2] == 14'h3C00) begin
      exp_rd = (reset || !CYC_EN) ? 32'd0 : m_cyc;
    end else if (addr[15:2] == 14'h3C02) begin
      exp_rd = reset ? 32'd1
                     : {15'b0, m_ovf, 8'(cnt), 6'b0, cnt == int'(FIFO_DEPTH), cnt == 0};
    end
    check("m_tx_valid", 32'(o_tx_valid), 32'(!reset && cnt > 0));
    check("m_tx_data", o_tx_data, (reset || cnt == 0) ? 32'd0 : m_q[0]);
    check("m_overflow", 32'(o_overflow), 32'(!reset && m_ovf));
    if (known) check("m_rdata", o_data, exp_rd);
  end

  task automatic drive(input logic [15:0] a, input logic w, input logic [31:0] d,
                       input logic rdy, input logic rst);
    @(negedge clk);
    addr = a; rw = w; wdata = d; tx_ready = rdy; reset = rst;
    #1;
  endtask

  initial begin
    reset = 1'b1; rw = 1'b0; addr = 16'hF008; wdata = 32'd0; tx_ready = 1'b0;

    drive(16'hF008, 0, 0, 0, 1);
    check("rst_status", o_data, 32'h0000_0001);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    drive(16'hF000, 0, 0, 0, 1);
    check("rst_cycle", o_data, 32'd0);
    drive(16'hF000, 0, 0, 0, 0);
    check("cycle_first", o_data, 32'd0);
    drive(16'hF000, 0, 0, 0, 0);
    check("cycle_second", o_data, CYC_EN ? 32'd1 : 32'd0);

    drive(16'h0010, 1, 32'hDEAD_BEEF, 0, 0);
    drive(16'h0010, 0, 0, 0, 0);
    check("ram_read", o_data, 32'hDEAD_BEEF);
    drive(16'h1010, 0, 0, 0, 0);
    check("ram_alias", o_data, 32'hDEAD_BEEF);

    for (int i = 1; i <= 8; i++) drive(16'hF004, 1, 32'(i), 0, 0);
    drive(16'hF008, 0, 0, 0, 0);
    check("status_full", o_data, 32'h0000_0802);
    check("head_first", o_tx_data, 32'd1);
    drive(16'hF004, 1, 32'h99, 0, 0);
    drive(16'hF008, 0, 0, 0, 0);
    check("status_ovf", o_data, 32'h0001_0802);
    check("overflow_set", 32'(o_overflow), 32'd1);

    for (int k = 1; k <= 8; k++) begin
      drive(16'hF004, 0, 0, 1, 0);
      check("drain_order", o_tx_data, 32'(k));
    end
    drive(16'hF008, 0, 0, 0, 0);
    check("drained_valid", 32'(o_tx_valid), 32'd0);
    check("drained_status", o_data, 32'h0001_0001);

    drive(16'hF008, 1, 32'h0001_0000, 0, 0);
    for (int i = 0; i < 8; i++) drive(16'hF004, 1, 32'h11 + 32'(i), 0, 0);
    drive(16'hF004, 1, 32'hAA, 1, 0);
    drive(16'hF008, 0, 0, 0, 0);
    check("full_pushpop_cnt", o_data, 32'h0000_0802);
    check("ovf_cleared", 32'(o_overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(16'hF004, 0, 0, 1, 0);
      check("pushpop_order", o_tx_data, (k < 7) ? 32'h12 + 32'(k) : 32'hAA);
    end

    drive(16'hF000, 1, 32'hFFFF_FFFE, 0, 0);
    drive(16'hF000, 0, 0, 0, 0);
    check("cycle_fffe", o_data, CYC_EN ? 32'hFFFF_FFFE : 32'd0);
    drive(16'hF000, 0, 0, 0, 0);
    check("cycle_ffff", o_data, CYC_EN ? 32'hFFFF_FFFF : 32'd0);
    drive(16'hF000, 0, 0, 0, 0);
    check("cycle_wrap", o_data, 32'd0);

    for (int i = 0; i < 9; i++) drive(16'hF004, 1, 32'h21 + 32'(i), 0, 0);
    for (int i = 0; i < 5; i++) drive(16'hF004, 0, 0, 1, 0);
    drive(16'hF008, 0, 0, 0, 0);
    check("three_left", o_data, 32'h0001_0300);
    drive(16'hF004, 1, 32'h77, 1, 1);
    check("rst_now_valid", 32'(o_tx_valid), 32'd0);
    check("rst_now_ovf", 32'(o_overflow), 32'd0);
    drive(16'hF008, 0, 0, 1, 1);
    check("rst_hold_status", o_data, 32'h0000_0001);
    drive(16'hF008, 0, 0, 0, 0);
    check("post_rst_status", o_data, 32'h0000_0001);
    check("post_rst_valid", 32'(o_tx_valid), 32'd0);
    drive(16'h0010, 0, 0, 0, 0);
    check("ram_kept", o_data, 32'hDEAD_BEEF);

    drive(16'hF004, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
